aes128_mode_core: RTL and testbench

- Parametrised successor of the AES-128 core. Adds a request FIFO of DEPTH jobs, valid/ready handshakes on both sides, per-job tags, and ECB or CBC chaining in either direction.
- Instantiates the existing aes128_encrypt and aes128_decrypt units and sequences jobs through them.
- Sits between the accelerator command interface and the two AES units.

---
 rtl/aes128_pkg.sv | 107 ++++++++++
 rtl/aes128_decrypt.sv | 56 +++++
 rtl/aes128_encrypt.sv | 47 ++++
 rtl/aes_req_fifo.sv | 43 ++++
 rtl/aes128_mode_core.sv | 100 ++++++++++
 tb/tb_aes128_mode_core.sv | 271 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes128_pkg.sv
// Shared types and AES round primitives for the mode core and the two AES units.
// The S-box is derived from the GF(2^8) inverse, so no 256-entry tables are needed.
package aes128_pkg;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} aes_mode_state_t;

  typedef struct packed {
    logic               dec;
    logic               cbc;
    logic               first;
    logic [BLOCK_W-1:0] key;
    logic [BLOCK_W-1:0] text;
    logic [BLOCK_W-1:0] iv;
  } aes_job_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x, input logic inv);
    logic [127:0] y;
    for (int k = 0; k < 16; k++)
      y[8*k +: 8] = inv ? inv_sbox(x[8*k +: 8]) : sbox(x[8*k +: 8]);
    return y;
  endfunction

  // Byte n of the block is state[n%4][n/4]; byte 0 sits in the top bits
  function automatic logic [127:0] shift_rows(input logic [127:0] x, input logic inv);
    logic [127:0] y;
    int src;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*src) -: 8];
      end
    return y;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] x, input logic inv);
    logic [127:0] y;
    logic [31:0]  m;
    logic [7:0]   a [4];
    m = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = x[127-8*(r+4*c) -: 8];
      for (int r = 0; r < 4; r++)
        y[127-8*(r+4*c) -: 8] = gmul(a[r], m[31:24]) ^ gmul(a[(r+1)%4], m[23:16]) ^
                                gmul(a[(r+2)%4], m[15:8]) ^ gmul(a[(r+3)%4], m[7:0]);
    end
    return y;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    return {n0, n1, n2, k[31:0] ^ n2};
  endfunction

  // Undo one key_next step; rc must be the constant that produced n
  function automatic logic [127:0] key_prev(input logic [127:0] n, input logic [7:0] rc);
    logic [31:0] w3;
    w3 = n[31:0] ^ n[63:32];
    return {n[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0},
            n[95:64] ^ n[127:96], n[63:32] ^ n[95:64], w3};
  endfunction
endpackage

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 decryptor: ten cycles to reach the last round key, then ten inverse rounds
// walking the schedule backwards. ready_o high while idle; done_o pulses with out_o valid.
module aes128_decrypt import aes128_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [BLOCK_W-1:0] key_i,
  input  logic [BLOCK_W-1:0] text_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [BLOCK_W-1:0] out_o
);
  logic               busy, expand;
  logic [3:0]         cnt;
  logic [7:0]         rcon;
  logic [BLOCK_W-1:0] rk, st, nk, pk, t;

  always_comb begin
    nk = key_next(rk, rcon);
    pk = key_prev(rk, rcon);
    t  = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ pk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; expand <= 1'b0; cnt <= '0; rcon <= '0; rk <= '0; st <= '0; done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (!busy) begin
        if (start_i) begin
          st <= text_i; rk <= key_i; rcon <= 8'h01; cnt <= '0; expand <= 1'b1; busy <= 1'b1;
        end
      end else if (expand) begin
        rk <= nk;
        // rcon is kept at 0x36 after the last step so key_prev can start from it
        if (cnt == 4'd9) begin
          st <= st ^ nk; expand <= 1'b0;
        end else begin
          rcon <= xtime(rcon); cnt <= cnt + 4'd1;
        end
      end else begin
        rk   <= pk;
        rcon <= (rcon == 8'h1b) ? 8'h80 : {1'b0, rcon[7:1]};
        cnt  <= cnt - 4'd1;
        if (cnt == 4'd0) begin
          st <= t; busy <= 1'b0; done_o <= 1'b1;
        end else begin
          st <= mix_columns(t, 1'b1);
        end
      end
    end
  end

  assign ready_o = !busy;
  assign out_o   = st;
endmodule

// File: rtl/aes128_encrypt.sv
// Iterative AES-128 encryptor: one round per cycle with on-the-fly key expansion.
// ready_o is high while idle; done_o pulses one cycle with out_o valid.
module aes128_encrypt import aes128_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [BLOCK_W-1:0] key_i,
  input  logic [BLOCK_W-1:0] text_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [BLOCK_W-1:0] out_o
);
  logic               busy;
  logic [3:0]         rnd;
  logic [7:0]         rcon;
  logic [BLOCK_W-1:0] rk, st, nk, t;

  always_comb begin
    nk = key_next(rk, rcon);
    t  = shift_rows(sub_bytes(st, 1'b0), 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; rnd <= '0; rcon <= '0; rk <= '0; st <= '0; done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (!busy) begin
        if (start_i) begin
          st <= text_i ^ key_i; rk <= key_i; rcon <= 8'h01; rnd <= 4'd1; busy <= 1'b1;
        end
      end else begin
        rk   <= nk;
        rcon <= xtime(rcon);
        rnd  <= rnd + 4'd1;
        if (rnd == 4'd10) begin
          st <= t ^ nk; busy <= 1'b0; done_o <= 1'b1;
        end else begin
          st <= mix_columns(t, 1'b0) ^ nk;
        end
      end
    end
  end

  assign ready_o = !busy;
  assign out_o   = st;
endmodule

// File: rtl/aes_req_fifo.sv
// Generic FIFO: combinational head read, registered occupancy, pointers wrap modulo DEPTH.
// Caller must not push when full or pop when empty.
module aes_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
endmodule

// File: rtl/aes128_mode_core.sv
// Queues AES-128 jobs and runs them one at a time through the encrypt/decrypt units with ECB/CBC
// chaining; pop one cycle after push, response the cycle after done; a held response stalls the queue.
module aes128_mode_core import aes128_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_dec_i,
  input  logic                       req_cbc_i,
  input  logic                       req_first_i,
  input  logic [TAG_W-1:0]           req_tag_i,
  input  logic [BLOCK_W-1:0]         req_key_i,
  input  logic [BLOCK_W-1:0]         req_text_i,
  input  logic [BLOCK_W-1:0]         req_iv_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [BLOCK_W-1:0]         rsp_text_o,
  output logic [TAG_W-1:0]           rsp_tag_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       busy_o
);
  localparam int EW = TAG_W + $bits(aes_job_t);

  aes_mode_state_t    state;
  aes_job_t           in_job, job;
  logic [TAG_W-1:0]   tag;
  logic [EW-1:0]      fifo_dout;
  logic [BLOCK_W-1:0] chain, chain_eff, unit_text, enc_out, dec_out;
  logic               arm, full, empty, push, pop;
  logic               enc_start, dec_start, enc_ready, dec_ready, enc_done, dec_done;

  assign in_job = '{dec: req_dec_i, cbc: req_cbc_i, first: req_first_i,
                    key: req_key_i, text: req_text_i, iv: req_iv_i};

  // arm keeps ready low in reset and for the first edge after release
  assign req_ready_o = arm & !full;
  assign push        = req_valid_i & req_ready_o;
  assign pop         = (state == IDLE) & !empty & !rsp_valid_o;
  assign busy_o      = !empty | (state != IDLE) | rsp_valid_o;

  aes_req_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din({req_tag_i, in_job}),
    .dout(fifo_dout), .full(full), .empty(empty), .level(level_o)
  );

  // First CBC job sees its IV in the same cycle the chain register is loaded
  assign chain_eff = (job.cbc & job.first) ? job.iv : chain;
  assign unit_text = (job.cbc & !job.dec) ? (job.text ^ chain_eff) : job.text;
  assign enc_start = (state == ISSUE) & !job.dec & enc_ready;
  assign dec_start = (state == ISSUE) & job.dec & dec_ready;

  aes128_encrypt u_enc (
    .clk(clk), .rst_n(rst_n), .start_i(enc_start), .key_i(job.key), .text_i(unit_text),
    .ready_o(enc_ready), .done_o(enc_done), .out_o(enc_out)
  );

  aes128_decrypt u_dec (
    .clk(clk), .rst_n(rst_n), .start_i(dec_start), .key_i(job.key), .text_i(unit_text),
    .ready_o(dec_ready), .done_o(dec_done), .out_o(dec_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; job <= '0; tag <= '0; chain <= '0; arm <= 1'b0;
      rsp_valid_o <= 1'b0; rsp_text_o <= '0; rsp_tag_o <= '0;
    end else begin
      arm <= 1'b1;
      case (state)
        IDLE: if (pop) begin
          {tag, job} <= fifo_dout;
          state      <= ISSUE;
        end
        ISSUE: if (enc_start | dec_start) begin
          if (job.cbc & job.first) chain <= job.iv;
          state <= WAIT;
        end
        WAIT: if (job.dec ? dec_done : enc_done) begin
          if (job.dec) begin
            rsp_text_o <= job.cbc ? (dec_out ^ chain) : dec_out;
            if (job.cbc) chain <= job.text;
          end else begin
            rsp_text_o <= enc_out;
            if (job.cbc) chain <= enc_out;
          end
          rsp_tag_o   <= tag;
          rsp_valid_o <= 1'b1;
          state       <= RESP;
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_mode_core.sv
// Directed bench for aes128_mode_core using FIPS-197 and SP800-38A vectors.
module tb_aes128_mode_core;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] C3 = 128'h73bed6b8e3c1743b7116e69e22229516;
  localparam logic [127:0] E1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0, req_dec = 1'b0, req_cbc = 1'b0, req_first = 1'b0;
  logic [TAG_W-1:0]   req_tag = '0;
  logic [127:0]       req_key = '0, req_text = '0, req_iv = '0;
  logic               rsp_ready = 1'b0;
  logic               req_ready_o, rsp_valid_o, busy_o;
  logic [127:0]       rsp_text_o;
  logic [TAG_W-1:0]   rsp_tag_o;
  logic [$clog2(DEPTH+1)-1:0] level_o;

  int errors = 0;
  int checks = 0;

  aes128_mode_core #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_dec_i(req_dec),
    .req_cbc_i(req_cbc), .req_first_i(req_first), .req_tag_i(req_tag),
    .req_key_i(req_key), .req_text_i(req_text), .req_iv_i(req_iv),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_text_o(rsp_text_o),
    .rsp_tag_o(rsp_tag_o), .level_o(level_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push_job(input logic dec, input logic cbc, input logic first,
                          input logic [TAG_W-1:0] tag, input logic [127:0] key,
                          input logic [127:0] text, input logic [127:0] iv);
    int n = 0;
    req_dec = dec; req_cbc = cbc; req_first = first; req_tag = tag;
    req_key = key; req_text = text; req_iv = iv; req_valid = 1'b1;
    while (!req_ready_o && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready_o) begin
      errors++;
      $display("FAIL push_timeout tag=%0d: req_ready_o=%b after %0d cycles, required 1", tag, req_ready_o, n);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [127:0] txt, output logic [TAG_W-1:0] tg);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid_o && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!rsp_valid_o) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid_o=%b after %0d cycles, required 1", rsp_valid_o, n);
      txt = '0; tg = '0;
    end else begin
      txt = rsp_text_o; tg = rsp_tag_o;
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready_o, rsp_valid_o, busy_o, level_o} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b level=%0d, required all 0",
               req_ready_o, rsp_valid_o, busy_o, level_o);
    end
    checks++;
    if ({rsp_text_o, rsp_tag_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got text=%h tag=%0d, required 0", rsp_text_o, rsp_tag_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, required 1", req_ready_o);
    end
  endtask

  task automatic test_ecb_enc;
    logic [127:0] txt; logic [TAG_W-1:0] tg;
    push_job(1'b0, 1'b0, 1'b0, 4'd3, K1, P0, '0);
    checks++;
    if (level_o !== 3'd1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL level_after_push: got level=%0d busy=%b, required 1/1", level_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (level_o !== 3'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL level_after_pop: got level=%0d busy=%b, required 0/1", level_o, busy_o);
    end
    wait_rsp(txt, tg);
    checks++;
    if (txt !== C0 || tg !== 4'd3) begin
      errors++;
      $display("FAIL ecb_enc: got %h tag %0d, required %h tag 3", txt, tg, C0);
    end
  endtask

  task automatic test_ecb_dec;
    logic [127:0] txt; logic [TAG_W-1:0] tg;
    push_job(1'b1, 1'b0, 1'b0, 4'd5, K1, C0, '0);
    wait_rsp(txt, tg);
    checks++;
    if (txt !== P0 || tg !== 4'd5) begin
      errors++;
      $display("FAIL ecb_dec: got %h tag %0d, required %h tag 5", txt, tg, P0);
    end
  endtask

  task automatic test_cbc_enc;
    logic [127:0] txt; logic [TAG_W-1:0] tg;
    push_job(1'b0, 1'b1, 1'b1, 4'd1, K2, P1, IV);
    push_job(1'b0, 1'b1, 1'b0, 4'd2, K2, P2, '0);
    wait_rsp(txt, tg);
    checks++;
    if (txt !== C1 || tg !== 4'd1) begin
      errors++;
      $display("FAIL cbc_enc_1: got %h tag %0d, required %h tag 1", txt, tg, C1);
    end
    wait_rsp(txt, tg);
    checks++;
    if (txt !== C2 || tg !== 4'd2) begin
      errors++;
      $display("FAIL cbc_enc_2: got %h tag %0d, required %h tag 2", txt, tg, C2);
    end
  endtask

  task automatic test_cbc_dec;
    logic [127:0] txt; logic [TAG_W-1:0] tg;
    logic [127:0] exp_txt [4];
    exp_txt[0] = P1; exp_txt[1] = P2; exp_txt[2] = E1; exp_txt[3] = P3;
    push_job(1'b1, 1'b1, 1'b1, 4'd4, K2, C1, IV);
    push_job(1'b1, 1'b1, 1'b0, 4'd5, K2, C2, '0);
    push_job(1'b0, 1'b0, 1'b0, 4'd6, K2, P1, '0);
    push_job(1'b1, 1'b1, 1'b0, 4'd7, K2, C3, '0);
    for (int i = 0; i < 4; i++) begin
      wait_rsp(txt, tg);
      checks++;
      if (txt !== exp_txt[i] || tg !== 4'(i + 4)) begin
        errors++;
        $display("FAIL cbc_dec_seq%0d: got %h tag %0d, required %h tag %0d", i, txt, tg, exp_txt[i], i + 4);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] txt; logic [TAG_W-1:0] tg;
    int seen_ready = 0;
    for (int t = 0; t <= DEPTH; t++) begin
      if (t % 2 == 0) push_job(1'b0, 1'b0, 1'b0, 4'(t), K1, P0, '0);
      else            push_job(1'b1, 1'b0, 1'b0, 4'(t), K1, C0, '0);
    end
    checks++;
    if (level_o !== 3'(DEPTH) || req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got level=%0d ready=%b, required %0d/0", level_o, req_ready_o, DEPTH);
    end
    req_dec = 1'b0; req_cbc = 1'b0; req_tag = 4'(DEPTH + 1); req_valid = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (req_ready_o) seen_ready++;
    end
    req_valid = 1'b0;
    checks++;
    if (seen_ready !== 0 || level_o !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL bp_stall: ready seen %0d cycles, level=%0d, required 0 cycles, level %0d",
               seen_ready, level_o, DEPTH);
    end
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'd0) begin
      errors++;
      $display("FAIL bp_held_rsp: got valid=%b tag=%0d, required 1 tag 0", rsp_valid_o, rsp_tag_o);
    end
    for (int t = 0; t <= DEPTH; t++) begin
      wait_rsp(txt, tg);
      checks++;
      if (tg !== 4'(t)) begin
        errors++;
        $display("FAIL bp_order%0d: got tag %0d, required %0d", t, tg, t);
      end
      checks++;
      if (txt !== ((t % 2 == 0) ? C0 : P0)) begin
        errors++;
        $display("FAIL bp_text%0d: got %h, required %h", t, txt, (t % 2 == 0) ? C0 : P0);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] txt; logic [TAG_W-1:0] tg;
    push_job(1'b0, 1'b0, 1'b0, 4'd1, K1, P0, '0);
    push_job(1'b0, 1'b0, 1'b0, 4'd2, K1, P0, '0);
    push_job(1'b0, 1'b0, 1'b0, 4'd3, K1, P0, '0);
    repeat (2) @(negedge clk);
    checks++;
    if (level_o !== 3'd2 || rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: got level=%0d valid=%b, required 2/0", level_o, rsp_valid_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, busy_o, level_o, rsp_tag_o, rsp_text_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got ready=%b valid=%b busy=%b level=%0d tag=%0d text=%h, required all 0",
               req_ready_o, rsp_valid_o, busy_o, level_o, rsp_tag_o, rsp_text_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_job(1'b1, 1'b0, 1'b0, 4'd9, K1, C0, '0);
    wait_rsp(txt, tg);
    checks++;
    if (txt !== P0 || tg !== 4'd9) begin
      errors++;
      $display("FAIL post_reset_ecb: got %h tag %0d, required %h tag 9", txt, tg, P0);
    end
    // chain was cleared by reset, so CBC without an IV load behaves like ECB
    push_job(1'b0, 1'b1, 1'b0, 4'd10, K1, P0, '0);
    wait_rsp(txt, tg);
    checks++;
    if (txt !== C0 || tg !== 4'd10) begin
      errors++;
      $display("FAIL cbc_zero_chain: got %h tag %0d, required %h tag 10", txt, tg, C0);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || level_o !== 3'd0 || rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL final_idle: got busy=%b level=%0d valid=%b, required 0/0/0", busy_o, level_o, rsp_valid_o);
    end
  endtask

  initial begin
    test_reset;
    test_ecb_enc;
    test_ecb_dec;
    test_cbc_enc;
    test_cbc_dec;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
